// File: rtl/camera_pkg.sv
// Shared definitions for the OV7670 camera bring-up path: state encoding and
// default sequencing constants for a 25 MHz camera clock.
package camera_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_PWR_UP     = 3'd1;
    localparam logic [2:0] ST_RST_ASSERT = 3'd2;
    localparam logic [2:0] ST_RST_WAIT   = 3'd3;
    localparam logic [2:0] ST_CONFIG     = 3'd4;
    localparam logic [2:0] ST_SETTLE     = 3'd5;
    localparam logic [2:0] ST_RUN        = 3'd6;
    localparam logic [2:0] ST_FAULT      = 3'd7;

    localparam int DEF_CLK_FREQ          = 25000000;
    localparam int DEF_PWR_WAIT_CYC      = 75000;
    localparam int DEF_RST_PULSE_CYC     = 25000;
    localparam int DEF_RST_WAIT_CYC      = 25000;
    localparam int DEF_SETTLE_FRAMES     = 10;
    localparam int DEF_CFG_TIMEOUT_CYC   = 2500000;
    localparam int DEF_FRAME_TIMEOUT_CYC = 2500000;
    localparam int DEF_MAX_RETRIES       = 3;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Optional 2-flop synchronizer followed by a registered rising-edge detect.
// With SYNC=1 a raw rise shows up on 'rise' three clocks later; with SYNC=0 one clock later.
module sync_edge_detect #(
    parameter bit SYNC = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic level;
    logic prev;

    generate
        if (SYNC) begin : g_sync
            logic meta;
            logic sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta   <= 1'b0;
                    sync_q <= 1'b0;
                end else begin
                    meta   <= sig;
                    sync_q <= meta;
                end
            end
            assign level = sync_q;
        end else begin : g_nosync
            assign level = sig;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= level;
            rise <= level & ~prev;
        end
    end

endmodule

// File: rtl/camera_bringup_ctrl.sv
// Power-up / reset / config / settle sequencer for the OV7670 camera, with
// VSYNC and config watchdogs that retry the reset sequence before faulting.
//
// state      | meaning
// IDLE       | camera powered down, waiting for enable
// PWR_UP     | PWDN released, waiting for supplies to settle
// RST_ASSERT | camera reset pin held low
// RST_WAIT   | reset released, waiting before register config
// CONFIG     | config sequencer running, waiting for cfg_done edge
// SETTLE     | discarding initial frames
// RUN        | capture enabled, VSYNC watchdog active
// FAULT      | retry limit reached, held until enable drops
module camera_bringup_ctrl
    import camera_pkg::*;
#(
    parameter int CLK_FREQ          = DEF_CLK_FREQ,
    parameter int PWR_WAIT_CYC      = DEF_PWR_WAIT_CYC,
    parameter int RST_PULSE_CYC     = DEF_RST_PULSE_CYC,
    parameter int RST_WAIT_CYC      = DEF_RST_WAIT_CYC,
    parameter int SETTLE_FRAMES     = DEF_SETTLE_FRAMES,
    parameter int CFG_TIMEOUT_CYC   = DEF_CFG_TIMEOUT_CYC,
    parameter int FRAME_TIMEOUT_CYC = DEF_FRAME_TIMEOUT_CYC,
    parameter int MAX_RETRIES       = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       cfg_done,
    input  logic       vsync_in,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       cfg_start,
    output logic       capture_en,
    output logic       ready,
    output logic       error,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_o
);

    localparam int CNT_MAX = max_of(max_of(max_of(PWR_WAIT_CYC, RST_PULSE_CYC),
                                           max_of(RST_WAIT_CYC, CFG_TIMEOUT_CYC)),
                                    FRAME_TIMEOUT_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int FRAME_W = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;

    generate
        if (MAX_RETRIES < 1 || MAX_RETRIES > 3 || CLK_FREQ <= 0) begin : g_bad_param
            $error("camera_bringup_ctrl: MAX_RETRIES must be 1..3 and CLK_FREQ positive");
        end
    endgenerate

    // Loads are N-1 so that a phase lasts exactly N cycles before the zero compare fires.
    localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'(PWR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RWAIT = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CFG   = CNT_W'(CFG_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_FRAME = CNT_W'(FRAME_TIMEOUT_CYC - 1);

    logic [2:0]         state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx, cnt_dec;
    logic [FRAME_W-1:0] frame_cnt, frame_nx;
    logic [1:0]         retry_nx;
    logic               expired, fail, last_frame, last_retry;
    logic               vs_rise, cfg_rise;

    sync_edge_detect #(.SYNC(1'b1)) u_vsync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (vsync_in),
        .rise  (vs_rise)
    );

    sync_edge_detect #(.SYNC(1'b0)) u_cfg_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (cfg_done),
        .rise  (cfg_rise)
    );

    assign expired    = (cnt == '0);
    assign cnt_dec    = cnt - CNT_W'(1);
    assign last_frame = ((int'(frame_cnt) + 1) == SETTLE_FRAMES);
    assign last_retry = ((int'(retry_cnt) + 1) == MAX_RETRIES);
    assign state_o    = state;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        frame_nx = frame_cnt;
        retry_nx = retry_cnt;
        fail     = 1'b0;
        if (!enable) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            frame_nx = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_PWR_UP;
                    cnt_nx   = LD_PWR;
                    retry_nx = '0;
                end
                ST_PWR_UP: begin
                    if (expired) begin
                        state_nx = ST_RST_ASSERT;
                        cnt_nx   = LD_RST;
                    end else begin
                        cnt_nx = cnt_dec;
                    end
                end
                ST_RST_ASSERT: begin
                    if (expired) begin
                        state_nx = ST_RST_WAIT;
                        cnt_nx   = LD_RWAIT;
                    end else begin
                        cnt_nx = cnt_dec;
                    end
                end
                ST_RST_WAIT: begin
                    if (expired) begin
                        state_nx = ST_CONFIG;
                        cnt_nx   = LD_CFG;
                    end else begin
                        cnt_nx = cnt_dec;
                    end
                end
                ST_CONFIG: begin
                    if (cfg_rise) begin
                        state_nx = ST_SETTLE;
                        frame_nx = '0;
                        cnt_nx   = LD_FRAME;
                    end else if (expired) begin
                        fail = 1'b1;
                    end else begin
                        cnt_nx = cnt_dec;
                    end
                end
                ST_SETTLE: begin
                    if (vs_rise) begin
                        cnt_nx = LD_FRAME;
                        if (last_frame) begin
                            state_nx = ST_RUN;
                        end else begin
                            frame_nx = frame_cnt + FRAME_W'(1);
                        end
                    end else if (expired) begin
                        fail = 1'b1;
                    end else begin
                        cnt_nx = cnt_dec;
                    end
                end
                ST_RUN: begin
                    if (vs_rise) begin
                        cnt_nx = LD_FRAME;
                    end else if (expired) begin
                        fail = 1'b1;
                    end else begin
                        cnt_nx = cnt_dec;
                    end
                end
                default: begin
                end
            endcase

            // Power stays on across retries; only the reset pulse is replayed.
            if (fail) begin
                if (last_retry) begin
                    state_nx = ST_FAULT;
                    retry_nx = 2'(MAX_RETRIES);
                end else begin
                    state_nx = ST_RST_ASSERT;
                    cnt_nx   = LD_RST;
                    retry_nx = (retry_cnt == 2'd3) ? retry_cnt : retry_cnt + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            frame_cnt  <= '0;
            retry_cnt  <= '0;
            cam_pwdn   <= 1'b1;
            cam_rst_n  <= 1'b0;
            cfg_start  <= 1'b0;
            capture_en <= 1'b0;
            ready      <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            frame_cnt  <= frame_nx;
            retry_cnt  <= retry_nx;
            cam_pwdn   <= (state_nx == ST_IDLE);
            cam_rst_n  <= !(state_nx == ST_IDLE || state_nx == ST_RST_ASSERT ||
                            state_nx == ST_FAULT);
            cfg_start  <= (state == ST_RST_WAIT) && (state_nx == ST_CONFIG);
            capture_en <= (state_nx == ST_RUN);
            ready      <= (state_nx == ST_RUN);
            error      <= (state_nx == ST_FAULT);
        end
    end

endmodule

// File: doc/camera_bringup_ctrl.md
Name: camera_bringup_ctrl

Overview:
Top-level power-up sequencer for the OV7670 camera path, running in the 25 MHz camera clock domain.
- Drives the camera PWDN and RESET pins, then issues the register-configuration start pulse and waits for config done.
- Waits a number of frames for the sensor to settle before enabling pixel capture.
- Monitors VSYNC while running and re-runs the reset/config sequence on a config or frame timeout, up to a retry limit, then declares a fault.

Parameters:
CLK_FREQ, 25000000, clk frequency in Hz (documentation only; all timing uses the cycle parameters below)
PWR_WAIT_CYC, 75000, cycles with PWDN released before reset is asserted (3 ms)
RST_PULSE_CYC, 25000, cycles cam_rst_n is held low (1 ms)
RST_WAIT_CYC, 25000, cycles after reset release before config start (1 ms)
SETTLE_FRAMES, 10, VSYNC rising edges to discard before capture_en
CFG_TIMEOUT_CYC, 2500000, max cycles from cfg_start to cfg_done rising edge
FRAME_TIMEOUT_CYC, 2500000, max cycles between VSYNC rising edges in SETTLE/RUN
MAX_RETRIES, 3, failed attempts allowed before FAULT (1..3)

Ports:
clk  in  1  camera-domain clock (25 MHz)
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; high = bring camera up and keep it running
cfg_done  in  1  done level from the config sequencer
vsync_in  in  1  raw camera VSYNC (asynchronous to clk)
cam_pwdn  out  1  camera power-down pin, 1 = powered down
cam_rst_n  out  1  camera reset pin, active low
cfg_start  out  1  one-cycle start pulse to the config sequencer
capture_en  out  1  enables the pixel capture path
ready  out  1  high while in RUN
error  out  1  high while in FAULT
retry_cnt  out  2  failed attempts in the current enable session
state_o  out  3  current state encoding, for debug

Behaviour:
- Reset (async, rst_n=0): state IDLE, cam_pwdn=1, cam_rst_n=0, cfg_start=0, capture_en=0, ready=0, error=0, retry_cnt=0, counters cleared. All outputs are registered.
- VSYNC: 2-flop synchronizer followed by a registered rising-edge detect. An edge is seen 3 clk after the raw transition.
- cfg_done: registered rising-edge detect. Only an edge counts as done; a level already high does not.
- One shared down-counter, width $clog2 of the largest cycle parameter, plus a frame counter of width $clog2(SETTLE_FRAMES+1).
- States (state_o encoding):
  - IDLE=0
  - PWR_UP=1
  - RST_ASSERT=2
  - RST_WAIT=3
  - CONFIG=4
  - SETTLE=5
  - RUN=6
  - FAULT=7
- IDLE: pwdn=1, rst_n=0. On enable=1: go to PWR_UP with pwdn=0 on the next edge, load PWR_WAIT_CYC, clear retry_cnt.
- PWR_UP: when count expires, go to RST_ASSERT and load RST_PULSE_CYC.
- RST_ASSERT: cam_rst_n=0. On expiry: go to RST_WAIT, cam_rst_n=1, load RST_WAIT_CYC.
- RST_WAIT: on expiry go to CONFIG. cfg_start=1 for exactly that one cycle; load CFG_TIMEOUT_CYC.
- CONFIG:
  - On a cfg_done edge: go to SETTLE, clear the frame counter, load FRAME_TIMEOUT_CYC.
  - On timeout: retry.
- SETTLE:
  - Each VSYNC edge increments the frame counter and reloads the timeout.
  - On reaching SETTLE_FRAMES: go to RUN; capture_en=1 and ready=1 from the next cycle.
  - On timeout: retry.
- RUN: each VSYNC edge reloads FRAME_TIMEOUT_CYC. On timeout: capture_en=0, ready=0, then retry.
- Retry:
  - If retry_cnt+1 == MAX_RETRIES: go to FAULT and set retry_cnt=MAX_RETRIES.
  - Otherwise: increment retry_cnt, go to RST_ASSERT with cam_rst_n=0, load RST_PULSE_CYC. Power stays on.
- FAULT: error=1, capture_en=0, pwdn=0, cam_rst_n=0. Left only via enable=0.
- enable=0 in any state: next cycle go to IDLE with pwdn=1, rst_n=0, capture_en=0, ready=0, error=0. This has priority over every other transition, including a simultaneous cfg_done or VSYNC edge. retry_cnt holds until the next enable.
- A VSYNC edge in the same cycle as timeout expiry counts as the edge; no timeout is taken.
- cfg_done edges outside CONFIG are ignored. VSYNC edges outside SETTLE/RUN are ignored.
- retry_cnt saturates and never wraps.

Decomposition:
- Shared package camera_pkg: state encoding localparams (width 3) and the default timing constants.
- One sub-module: sync_edge_detect, a 2-flop synchronizer plus rising-edge detect with async active-low reset, instanced for vsync_in. The cfg_done path uses only the edge stage (SYNC=0 parameter).

Test Plan:
Bench parameters: PWR_WAIT_CYC=10, RST_PULSE_CYC=5, RST_WAIT_CYC=5, SETTLE_FRAMES=2, CFG_TIMEOUT_CYC=100, FRAME_TIMEOUT_CYC=200, MAX_RETRIES=2.
- Nominal bring-up: reset released, enable=1 → pwdn falls 1 cycle later; rst_n low for 5 cycles; single cfg_start pulse. cfg_done rises 20 cycles later, then 2 VSYNC pulses 50 cycles apart → capture_en=1 and ready=1 with state_o=6.
- Config timeout: cfg_done held 0 → after 100 cycles retry_cnt=1 and cam_rst_n=0 again. Second timeout → state_o=7, error=1, retry_cnt=2, capture_en=0.
- VSYNC loss in RUN: stop VSYNC → 200 cycles after the last edge capture_en=0 and retry_cnt=1. Resume cfg_done and VSYNC → ready=1 again.
- Edge vs timeout tie: VSYNC edge lands exactly at counter expiry in SETTLE → no retry; retry_cnt stays 0.
- enable dropped mid-CONFIG together with a cfg_done edge → IDLE next cycle; pwdn=1, cam_rst_n=0, cfg_start=0, no SETTLE entry.
- Async reset asserted in RUN → all outputs at reset values with no clk edge required; FAULT exits only when enable goes low.
